// File: rtl/wep_sched_pkg.sv
// -----------------------------------------------------------------------------
// wep_sched_pkg
// Shared types for the WEP frame scheduler: scheduler state encoding,
// completion status codes and the frame descriptor record handed to the
// RC4 encrypt engine.
// -----------------------------------------------------------------------------
package wep_sched_pkg;

    // Scheduler states; ABORT is only reachable when the watchdog is built in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        ABORT = 3'd3,
        CPL   = 3'd4
    } sched_state_e;

    // Completion status codes reported on cpl_status.
    localparam logic CPL_OK      = 1'b0;
    localparam logic CPL_TIMEOUT = 1'b1;

    // One frame descriptor as latched for the engine.
    typedef struct packed {
        logic [31:0] plain_addr;
        logic [31:0] frame_size;
        logic [31:0] cipher_addr;
        logic [31:0] seed_msw;
        logic [31:0] seed_lsw;
    } wep_desc_t;

endpackage

// File: rtl/wep_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wep_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at index ptr
// and wraps, so requester ptr has highest priority. The pointer register
// lives in the parent.
// Ports:
//   req        in   NREQ          request vector
//   ptr        in   clog2(NREQ)   highest-priority index this cycle
//   en         in   1             arbitration enable (no grant when low)
//   grant      out  NREQ          one-hot grant (all zero when none)
//   grant_idx  out  clog2(NREQ)   encoded index of the grant (0 when none)
// -----------------------------------------------------------------------------
module wep_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IDXW = $clog2(NREQ);

    int   cand_s;
    logic found_s;

    // Rotating priority search: first requester at or after ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = (int'(ptr) + i) % NREQ;
            if (en && req[cand_s] && !found_s) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s[IDXW-1:0];
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/wep_frame_scheduler.sv
// -----------------------------------------------------------------------------
// wep_frame_scheduler
// Multi-requester front end for the WEP RC4 encrypt engine. Grants the engine
// round-robin, latches the winning descriptor, pulses the engine start, waits
// for done and returns a completion record. Owns the engine reset so a hung
// frame can be aborted.
// Build option: define WEP_SCHED_TIMEOUT_EN to include the per-run watchdog
// and the ABORT state (engine held in reset for 2 cycles, status timeout).
// Ports:
//   clk, nreset (sync, active-low)
//   req_valid/req_ready            per-requester descriptor handshake
//   req_plain_addr .. req_seed_lsw packed 32-bit slices, slice k = [32k+31:32k]
//   eng_start_encrypt              one-cycle start pulse
//   eng_plain_addr .. eng_seed_lsw latched descriptor, stable until next grant
//   eng_nreset                     engine reset (sync, active-low), registered
//   eng_done                       engine completion pulse
//   cpl_valid/cpl_ready/cpl_id/cpl_status  completion record
//   busy                           high whenever not IDLE
// -----------------------------------------------------------------------------
module wep_frame_scheduler
    import wep_sched_pkg::*;
#(
    parameter int          NREQ           = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_plain_addr,
    input  logic [32*NREQ-1:0]      req_frame_size,
    input  logic [32*NREQ-1:0]      req_cipher_addr,
    input  logic [32*NREQ-1:0]      req_seed_msw,
    input  logic [32*NREQ-1:0]      req_seed_lsw,
    output logic                    eng_start_encrypt,
    output logic [31:0]             eng_plain_addr,
    output logic [31:0]             eng_frame_size,
    output logic [31:0]             eng_cipher_addr,
    output logic [31:0]             eng_seed_msw,
    output logic [31:0]             eng_seed_lsw,
    output logic                    eng_nreset,
    input  logic                    eng_done,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [$clog2(NREQ)-1:0] cpl_id,
    output logic                    cpl_status,
    output logic                    busy
);

    localparam int IDXW = $clog2(NREQ);

    sched_state_e    state_r;
    sched_state_e    next_state_s;
    logic [IDXW-1:0] rr_ptr_r;
    logic [IDXW-1:0] ptr_next_s;
    logic [IDXW-1:0] cur_id_r;
    logic [NREQ-1:0] grant_s;
    logic [IDXW-1:0] grant_idx_s;
    logic            arb_en_s;
    logic            accept_s;
    wep_desc_t       req_desc_s [NREQ];
    wep_desc_t       desc_sel_s;
    wep_desc_t       desc_r;
    logic            eng_start_r;
    logic            eng_nreset_r;
    logic            cpl_valid_r;
    logic            busy_r;

    // Unpack the flat per-requester buses into descriptor records.
    for (genvar k = 0; k < NREQ; k++) begin : g_desc
        assign req_desc_s[k].plain_addr  = req_plain_addr[32*k +: 32];
        assign req_desc_s[k].frame_size  = req_frame_size[32*k +: 32];
        assign req_desc_s[k].cipher_addr = req_cipher_addr[32*k +: 32];
        assign req_desc_s[k].seed_msw    = req_seed_msw[32*k +: 32];
        assign req_desc_s[k].seed_lsw    = req_seed_lsw[32*k +: 32];
    end

    // Arbitration only in IDLE and never while reset is asserted, so
    // req_ready reads 0 during reset.
    assign arb_en_s = (state_r == IDLE) && nreset;

    wep_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .en        (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready  = grant_s;
    assign accept_s   = |grant_s;
    assign desc_sel_s = req_desc_s[grant_idx_s];
    // Winner+1 gets top priority next time, wrapping for non-power-of-2 NREQ.
    assign ptr_next_s = (grant_idx_s == IDXW'(NREQ - 1)) ? '0
                                                          : (grant_idx_s + IDXW'(32'd1));

`ifdef WEP_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt_r;
    logic        abort_cnt_r;
    logic        cpl_status_r;

    // Watchdog: cleared in START, counts every BUSY cycle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wd_cnt_r <= 32'd0;
        end else if (state_r == START) begin
            wd_cnt_r <= 32'd0;
        end else if (state_r == BUSY) begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Counts the two ABORT cycles.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            abort_cnt_r <= 1'b0;
        end else if (state_r == ABORT) begin
            abort_cnt_r <= abort_cnt_r + 1'b1;
        end else begin
            abort_cnt_r <= 1'b0;
        end
    end

    // Status is decided on the edge into CPL and held until the next one.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cpl_status_r <= CPL_OK;
        end else if ((state_r == BUSY) && (next_state_s == CPL)) begin
            cpl_status_r <= CPL_OK;
        end else if ((state_r == ABORT) && (next_state_s == CPL)) begin
            cpl_status_r <= CPL_TIMEOUT;
        end else begin
            cpl_status_r <= cpl_status_r;
        end
    end

    assign cpl_status = cpl_status_r;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign cpl_status       = CPL_OK;
`endif

    // Next-state logic; eng_done is only looked at in BUSY and beats the watchdog.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                next_state_s = BUSY;
            end
            BUSY: begin
                if (eng_done) begin
                    next_state_s = CPL;
`ifdef WEP_SCHED_TIMEOUT_EN
                end else if (wd_cnt_r == (TIMEOUT_CYCLES - 32'd1)) begin
                    next_state_s = ABORT;
`endif
                end else begin
                    next_state_s = BUSY;
                end
            end
`ifdef WEP_SCHED_TIMEOUT_EN
            ABORT: begin
                if (abort_cnt_r == 1'b1) begin
                    next_state_s = CPL;
                end else begin
                    next_state_s = ABORT;
                end
            end
`endif
            CPL: begin
                if (cpl_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = CPL;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            eng_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            cpl_valid_r  <= 1'b0;
            eng_nreset_r <= 1'b0;
        end else begin
            eng_start_r  <= (next_state_s == START);
            busy_r       <= (next_state_s != IDLE);
            cpl_valid_r  <= (next_state_s == CPL);
`ifdef WEP_SCHED_TIMEOUT_EN
            eng_nreset_r <= (next_state_s != ABORT);
`else
            eng_nreset_r <= 1'b1;
`endif
        end
    end

    // Descriptor, requester id and round-robin pointer update on a grant.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            desc_r   <= '0;
            cur_id_r <= '0;
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            desc_r   <= desc_sel_s;
            cur_id_r <= grant_idx_s;
            rr_ptr_r <= ptr_next_s;
        end else begin
            desc_r   <= desc_r;
            cur_id_r <= cur_id_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign eng_start_encrypt = eng_start_r;
    assign eng_plain_addr    = desc_r.plain_addr;
    assign eng_frame_size    = desc_r.frame_size;
    assign eng_cipher_addr   = desc_r.cipher_addr;
    assign eng_seed_msw      = desc_r.seed_msw;
    assign eng_seed_lsw      = desc_r.seed_lsw;
    assign eng_nreset        = eng_nreset_r;
    assign cpl_valid         = cpl_valid_r;
    assign cpl_id            = cur_id_r;
    assign busy              = busy_r;

endmodule
